// File: rtl/num_entry_ctrl.sv
// Push-button number-entry controller with compute sequencer; optional debouncer via `define DEBOUNCE_EN.
// Latency: press sampled at edge n -> edit/state change visible after edge n+3 (+DB_CYCLES with debounce).
// Backpressure: none; buttons are ignored while busy (LAUNCH/WAIT) and all but enter are ignored in SHOW.
module num_entry_ctrl #(
    parameter int              WIDTH     = 32,
    parameter int              DIGITS    = 9,
    parameter longint unsigned MAX_VAL   = 999_999_999,
    parameter int              DB_CYCLES = 50_000,
    localparam int             CW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_n,
    input  logic             dec_n,
    input  logic             next_n,
    input  logic             prev_n,
    input  logic             enter_n,
    output logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] step,
    output logic [CW-1:0]    cursor,
    output logic             start,
    input  logic             calc_done,
    input  logic [WIDTH-1:0] calc_res,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_sel,
    output logic             busy
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

    typedef enum logic [1:0] {S_EDIT, S_LAUNCH, S_WAIT, S_SHOW} state_t;

    state_t state, state_nxt;

    // Button order in all vectors: {enter, prev, next, dec, inc}
    logic [4:0] btn_n;
    logic [4:0] sync1, sync2, lvl, pressed, pressed_q, evt;

    assign btn_n = {enter_n, prev_n, next_n, dec_n, inc_n};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;

    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [DBW-1:0] cnt;
        logic           db;

        // Level flips on the DB_CYCLES-th consecutive sample that disagrees with it
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                db  <= 1'b1;
            end else if (sync2[i] == db) begin
                cnt <= '0;
            end else if (cnt == DBW'(DB_CYCLES - 1)) begin
                cnt <= '0;
                db  <= sync2[i];
            end else begin
                cnt <= cnt + DBW'(1);
            end
        end

        assign lvl[i] = db;
    end
`else
    assign lvl = sync2;
`endif

    assign pressed = ~lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            pressed_q <= '0;
            evt       <= '0;
        end else begin
            pressed_q <= pressed;
            evt       <= pressed & ~pressed_q;
        end
    end

    logic ev_inc, ev_dec, ev_next, ev_prev, ev_enter;
    assign {ev_enter, ev_prev, ev_next, ev_dec, ev_inc} = evt;

    always_ff @(posedge clk) begin
        if (rst) state <= S_EDIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b0;
        disp_sel  = 1'b0;
        case (state)
            S_EDIT:   if (ev_enter) state_nxt = S_LAUNCH;
            S_LAUNCH: begin
                start     = 1'b1;
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (calc_done) state_nxt = S_SHOW;
            end
            S_SHOW: begin
                disp_sel = 1'b1;
                if (ev_enter) state_nxt = S_EDIT;
            end
            default:  state_nxt = S_EDIT;
        endcase
    end

    // Edit arithmetic uses the pre-update step, so a same-cycle cursor move does not affect it
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] op_edit;
    logic [WIDTH-1:0] step_edit;
    logic [CW-1:0]    cursor_edit;

    always_comb begin
        sum         = {1'b0, operand} + {1'b0, step};
        op_edit     = operand;
        step_edit   = step;
        cursor_edit = cursor;
        if (ev_inc && !ev_dec)
            op_edit = (sum > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : sum[WIDTH-1:0];
        else if (ev_dec && !ev_inc)
            op_edit = (operand >= step) ? operand - step : '0;
        if (ev_next && !ev_prev && cursor < CW'(DIGITS - 1)) begin
            cursor_edit = cursor + CW'(1);
            step_edit   = step * WIDTH'(10);
        end else if (ev_prev && !ev_next && cursor > '0) begin
            cursor_edit = cursor - CW'(1);
            step_edit   = step / WIDTH'(10);
        end
    end

    logic [WIDTH-1:0] result;

    always_ff @(posedge clk) begin
        if (rst) begin
            operand <= '0;
            step    <= WIDTH'(1);
            cursor  <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_EDIT: begin
                    operand <= op_edit;
                    step    <= step_edit;
                    cursor  <= cursor_edit;
                end
                S_WAIT: if (calc_done) result <= calc_res;
                S_SHOW: if (ev_enter) begin
                    operand <= '0;
                    step    <= WIDTH'(1);
                    cursor  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign disp_value = (state == S_SHOW) ? result : operand;

endmodule

// File: tb/tb_num_entry_ctrl.sv
// Randomized self-checking bench for num_entry_ctrl against a press-level arithmetic model.
module tb_num_entry_ctrl;

    localparam int              W    = 32;
    localparam int              D    = 9;
    localparam longint unsigned MAXV = 999_999_999;
    localparam int              DBC  = 4;
`ifdef DEBOUNCE_EN
    localparam int XL = DBC;
`else
    localparam int XL = 0;
`endif

    logic          clk, rst;
    logic          inc_n, dec_n, next_n, prev_n, enter_n;
    logic [W-1:0]  operand, step, disp_value, calc_res;
    logic [3:0]    cursor;
    logic          start, calc_done, disp_sel, busy;

    num_entry_ctrl #(.WIDTH(W), .DIGITS(D), .MAX_VAL(MAXV), .DB_CYCLES(DBC)) dut (
        .clk(clk), .rst(rst),
        .inc_n(inc_n), .dec_n(dec_n), .next_n(next_n), .prev_n(prev_n), .enter_n(enter_n),
        .operand(operand), .step(step), .cursor(cursor), .start(start),
        .calc_done(calc_done), .calc_res(calc_res),
        .disp_value(disp_value), .disp_sel(disp_sel), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;

    always @(posedge clk) if (start) n_start++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: operand value and decimal cursor position
    longint unsigned m_op;
    int              m_cur;

    function automatic longint unsigned pow10(input int c);
        longint unsigned r = 1;
        for (int i = 0; i < c; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_apply(input logic [4:0] m);
        longint unsigned st = pow10(m_cur);
        if (m[0] && !m[1])      m_op = (m_op + st > MAXV) ? MAXV : m_op + st;
        else if (m[1] && !m[0]) m_op = (m_op >= st) ? m_op - st : 0;
        if (m[2] && !m[3] && m_cur < D - 1)  m_cur++;
        else if (m[3] && !m[2] && m_cur > 0) m_cur--;
    endtask

    task automatic check_edit(input string tag);
        chk({tag, ".op"},   operand,    m_op);
        chk({tag, ".step"}, step,       pow10(m_cur));
        chk({tag, ".cur"},  cursor,     m_cur);
        chk({tag, ".disp"}, disp_value, m_op);
        chk({tag, ".sel"},  disp_sel,   0);
        chk({tag, ".busy"}, busy,       0);
    endtask

    // mask bits: {enter, prev, next, dec, inc}
    task automatic press(input logic [4:0] m);
        @(negedge clk);
        {enter_n, prev_n, next_n, dec_n, inc_n} = ~m;
        repeat (8 + XL) @(negedge clk);
        {enter_n, prev_n, next_n, dec_n, inc_n} = '1;
        repeat (8 + XL) @(negedge clk);
    endtask

    task automatic edit(input logic [4:0] m, input int times);
        for (int i = 0; i < times; i++) begin
            press(m);
            model_apply(m);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_op  = 0;
        m_cur = 0;
    endtask

    task automatic pulse_done(input logic [W-1:0] r);
        @(negedge clk);
        calc_done = 1'b1;
        calc_res  = r;
        @(negedge clk);
        calc_done = 1'b0;
        calc_res  = $urandom;
        @(negedge clk);
    endtask

    localparam logic [4:0] INC = 5'b00001, DEC = 5'b00010, NXT = 5'b00100,
                           PRV = 5'b01000, ENT = 5'b10000;

    initial begin
        logic [W-1:0] r;
        rst = 1'b1;
        {enter_n, prev_n, next_n, dec_n, inc_n} = '1;
        calc_done = 1'b0;
        calc_res  = '0;
        m_op = 0;
        m_cur = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_edit("reset");
        chk("reset.start", start, 0);

        // three increments
        edit(INC, 3);
        check_edit("t1");
        chk("t1.op_const", operand, 3);

        // cursor moves interleaved with edits
        reset_dut();
        edit(NXT, 2); edit(INC, 1); edit(PRV, 1); edit(DEC, 1);
        check_edit("t2");
        chk("t2.op_const", operand, 90);

        // cursor clamps at the top digit, operand saturates
        reset_dut();
        edit(NXT, 12);
        chk("t3.cur_top", cursor, 8);
        chk("t3.step_top", step, 100_000_000);
        edit(INC, 10);
        check_edit("t3");
        chk("t3.sat", operand, 999_999_999);

        // dec below zero clamps; simultaneous opposite buttons cancel
        reset_dut();
        edit(INC, 5); edit(NXT, 1); edit(DEC, 1);
        chk("t4.dec_clamp", operand, 0);
        edit(INC, 2); edit(INC | DEC, 1);
        check_edit("t4.incdec");
        edit(NXT | PRV, 1);
        check_edit("t4.nxtprv");
        edit(PRV, 3);
        check_edit("t4.prv_floor");

        // randomized editing
        reset_dut();
        for (int i = 0; i < 200; i++) begin
            logic [4:0] m;
            m = {1'b0, 4'($urandom_range(1, 15))};
            if ($urandom_range(0, 2) == 0) m = INC;
            edit(m, 1);
            check_edit($sformatf("rnd%0d", i));
        end

        // launch / wait / show handshake
        reset_dut();
        edit(INC, 7); edit(NXT, 1); edit(INC, 2);
        chk("t5.op27", operand, 27);
        pulse_done(32'd99);
        chk("t5.done_in_edit_sel", disp_sel, 0);
        chk("t5.done_in_edit_disp", disp_value, 27);
        n_start = 0;
        @(negedge clk);
        enter_n = 1'b0;
        for (int k = 0; k < 3 + XL; k++) begin
            @(negedge clk);
            chk("t5.start_early", start, 0);
        end
        @(negedge clk);
        chk("t5.start_pulse", start, 1);
        chk("t5.busy_launch", busy, 1);
        @(negedge clk);
        chk("t5.start_end", start, 0);
        chk("t5.busy_wait", busy, 1);
        enter_n = 1'b1;
        repeat (8 + XL) @(negedge clk);
        press(INC); press(ENT); press(NXT);
        chk("t5.wait_op", operand, 27);
        chk("t5.wait_step", step, 10);
        chk("t5.wait_busy", busy, 1);
        chk("t5.wait_start", start, 0);
        chk("t5.one_start", n_start, 1);
        r = $urandom;
        pulse_done(r);
        chk("t5.show_disp", disp_value, r);
        chk("t5.show_sel", disp_sel, 1);
        chk("t5.show_busy", busy, 0);
        chk("t5.show_op", operand, 27);
        press(INC); press(DEC);
        chk("t5.show_ign_disp", disp_value, r);
        chk("t5.show_ign_op", operand, 27);
        press(ENT);
        m_op = 0;
        m_cur = 0;
        check_edit("t5.back");

        // value event together with enter, then reset while waiting
        press(INC | ENT);
        chk("t6.inc_then_launch", operand, 1);
        chk("t6.busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_op = 0;
        m_cur = 0;
        check_edit("t6.rst");
        chk("t6.rst_start", start, 0);
        pulse_done(32'd1234);
        check_edit("t6.done_ignored");
        edit(INC, 1);
        check_edit("t6.edit_after");
        chk("t6.starts", n_start, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
